// File: rtl/dlp_pkg.sv
// Shared definitions for the DLP register-write sequencer: entry format codes,
// FSM state encoding and the write-count helpers.
package dlp_pkg;

    typedef enum logic [1:0] {
        FMT_REG3 = 2'b00,
        FMT_REG4 = 2'b01,
        FMT_DMA  = 2'b10,
        FMT_TEXT = 2'b11
    } fmt_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WVS   = 3'd1,
        ST_WRITE = 3'd2,
        ST_HAND  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Register formats have the upper format bit clear.
    function automatic logic is_reg_fmt(fmt_t f);
        return !f[1];
    endfunction

    // REG3 uses wcount with 00 meaning three; REG4 always writes three.
    function automatic logic [1:0] write_count(fmt_t f, logic [1:0] wc);
        if (f == FMT_REG4 || wc == 2'b00)
            return 2'd3;
        return wc;
    endfunction

endpackage

// File: rtl/dlp_reg_wr_if.sv
// Signal bundle around the DLP register-write sequencer. The master modport is
// the sequencer side; the slave modport is the list-fetch / register-file side.
interface dlp_reg_wr_if;
    logic         dlp_rstn_mc;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   list_format;
    logic [1:0]   wcount;
    logic         wvs;
    logic [8:2]   aad;
    logic [8:2]   bad;
    logic [8:2]   cad;
    logic [127:0] dl_temp;
    logic         vsync_pulse;
    logic         reg_wr_req;
    logic [8:2]   reg_wr_addr;
    logic [31:0]  reg_wr_data;
    logic         reg_wr_ack;
    logic         hand_start;
    logic [1:0]   hand_fmt;
    logic         hand_done;
    logic         entry_done;
    logic         dlp_idle;

    modport master (
        input  dlp_rstn_mc, cmd_valid, list_format, wcount, wvs, aad, bad, cad,
               dl_temp, vsync_pulse, reg_wr_ack, hand_done,
        output cmd_ready, reg_wr_req, reg_wr_addr, reg_wr_data, hand_start,
               hand_fmt, entry_done, dlp_idle
    );

    modport slave (
        output dlp_rstn_mc, cmd_valid, list_format, wcount, wvs, aad, bad, cad,
               dl_temp, vsync_pulse, reg_wr_ack, hand_done,
        input  cmd_ready, reg_wr_req, reg_wr_addr, reg_wr_data, hand_start,
               hand_fmt, entry_done, dlp_idle
    );
endinterface

// File: rtl/dlp_reg_wr.sv
// DLP register-write sequencer: retires one display-list entry as up to three
// register writes or a DMA/TEXT handoff. Define DLP_WVS_WAIT_EN to build the vsync wait.
module dlp_reg_wr
    import dlp_pkg::*;
#(
    parameter int BYTES = 4
) (
    input  logic         hb_clk,
    input  logic         hb_rstn,
    input  logic         dlp_rstn_mc,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   list_format,
    input  logic [1:0]   wcount,
    input  logic         wvs,
    input  logic [8:2]   aad,
    input  logic [8:2]   bad,
    input  logic [8:2]   cad,
    input  logic [127:0] dl_temp,
    input  logic         vsync_pulse,
    output logic         reg_wr_req,
    output logic [8:2]   reg_wr_addr,
    output logic [31:0]  reg_wr_data,
    input  logic         reg_wr_ack,
    output logic         hand_start,
    output logic [1:0]   hand_fmt,
    input  logic         hand_done,
    output logic         entry_done,
    output logic         dlp_idle
);

    state_t      state, state_nx;
    fmt_t        fmt_q;
    logic [1:0]  cnt_q;
    logic [1:0]  idx;
    logic        hs_q;
    logic [8:2]  aad_q, bad_q, cad_q;
    logic [95:0] data_q;
    logic [8:2]  addr_sel;
    logic [31:0] data_sel;
    logic        accept;
    fmt_t        fmt_in;

    assign fmt_in = fmt_t'(list_format);
    assign accept = cmd_valid && (state == ST_IDLE);

`ifdef DLP_WVS_WAIT_EN
    logic unused_ok;
    assign unused_ok = ^{dl_temp[31:0], BYTES[0]};
`else
    logic unused_ok;
    assign unused_ok = ^{dl_temp[31:0], BYTES[0], wvs, vsync_pulse};
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
`ifdef DLP_WVS_WAIT_EN
                    if (wvs) state_nx = ST_WVS;
                    else
`endif
                    if (is_reg_fmt(fmt_in)) state_nx = ST_WRITE;
                    else                    state_nx = ST_HAND;
                end
            end
            ST_WVS: begin
`ifdef DLP_WVS_WAIT_EN
                if (vsync_pulse)
                    state_nx = is_reg_fmt(fmt_q) ? ST_WRITE : ST_HAND;
`else
                state_nx = ST_IDLE;
`endif
            end
            ST_WRITE: if (reg_wr_ack && idx == cnt_q - 2'd1) state_nx = ST_DONE;
            ST_HAND:  if (hand_done) state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
        // Abort outranks every other event, including a same-cycle ack.
        if (dlp_rstn_mc) state_nx = ST_IDLE;
    end

    always_ff @(posedge hb_clk or negedge hb_rstn) begin
        if (!hb_rstn) begin
            state <= ST_IDLE;
            fmt_q <= FMT_REG3;
            cnt_q <= 2'd0;
            idx   <= 2'd0;
            hs_q  <= 1'b0;
        end else begin
            state <= state_nx;
            hs_q  <= (state_nx == ST_HAND) && (state != ST_HAND);
            if (accept) begin
                fmt_q <= fmt_in;
                cnt_q <= write_count(fmt_in, wcount);
                idx   <= 2'd0;
            end else if (state == ST_WRITE && reg_wr_ack) begin
                idx <= idx + 2'd1;
            end
        end
    end

    always_ff @(posedge hb_clk) begin
        if (accept) begin
            aad_q  <= aad;
            bad_q  <= bad;
            cad_q  <= cad;
            data_q <= dl_temp[127:32];
        end
    end

    always_comb begin
        addr_sel = aad_q;
        data_sel = data_q[31:0];
        unique case (idx)
            2'd1: begin
                addr_sel = (fmt_q == FMT_REG4) ? aad_q + 7'd1 : bad_q;
                data_sel = data_q[63:32];
            end
            2'd2: begin
                addr_sel = (fmt_q == FMT_REG4) ? aad_q + 7'd2 : cad_q;
                data_sel = data_q[95:64];
            end
            default: ;
        endcase
    end

    // Address/data are forced to zero outside WRITE so reset values hold
    // even though the captured registers are not reset.
    assign cmd_ready   = (state == ST_IDLE);
    assign dlp_idle    = (state == ST_IDLE);
    assign reg_wr_req  = (state == ST_WRITE);
    assign reg_wr_addr = reg_wr_req ? addr_sel : 7'd0;
    assign reg_wr_data = reg_wr_req ? data_sel : 32'd0;
    assign hand_start  = hs_q && (state == ST_HAND);
    assign hand_fmt    = (state == ST_HAND || state == ST_DONE) ? fmt_q : 2'b00;
    assign entry_done  = (state == ST_DONE);

endmodule

// File: tb/tb_dlp_reg_wr.sv
// Directed bench for dlp_reg_wr; expectations follow the build's DLP_WVS_WAIT_EN setting.
module tb_dlp_reg_wr;
    import dlp_pkg::*;

    logic hb_clk = 1'b0;
    logic hb_rstn = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    localparam logic [127:0] DT = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;

    dlp_reg_wr_if bus();

    always #5 hb_clk = ~hb_clk;

    dlp_reg_wr #(.BYTES(4)) dut (
        .hb_clk      (hb_clk),
        .hb_rstn     (hb_rstn),
        .dlp_rstn_mc (bus.dlp_rstn_mc),
        .cmd_valid   (bus.cmd_valid),
        .cmd_ready   (bus.cmd_ready),
        .list_format (bus.list_format),
        .wcount      (bus.wcount),
        .wvs         (bus.wvs),
        .aad         (bus.aad),
        .bad         (bus.bad),
        .cad         (bus.cad),
        .dl_temp     (bus.dl_temp),
        .vsync_pulse (bus.vsync_pulse),
        .reg_wr_req  (bus.reg_wr_req),
        .reg_wr_addr (bus.reg_wr_addr),
        .reg_wr_data (bus.reg_wr_data),
        .reg_wr_ack  (bus.reg_wr_ack),
        .hand_start  (bus.hand_start),
        .hand_fmt    (bus.hand_fmt),
        .hand_done   (bus.hand_done),
        .entry_done  (bus.entry_done),
        .dlp_idle    (bus.dlp_idle)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge hb_clk);
        #1;
    endtask

    task automatic chk_write(input string tag, input logic [6:0] a, input logic [31:0] d);
        chk({tag, "_req"}, {31'd0, bus.reg_wr_req}, 32'd1);
        chk({tag, "_addr"}, {25'd0, bus.reg_wr_addr}, {25'd0, a});
        chk({tag, "_data"}, bus.reg_wr_data, d);
    endtask

    task automatic present(input logic [1:0] f, input logic [1:0] wc, input logic w,
                           input logic [6:0] a, input logic [6:0] b, input logic [6:0] c);
        bus.cmd_valid   = 1'b1;
        bus.list_format = f;
        bus.wcount      = wc;
        bus.wvs         = w;
        bus.aad         = a;
        bus.bad         = b;
        bus.cad         = c;
        bus.dl_temp     = DT;
    endtask

    task automatic scramble();
        bus.cmd_valid   = 1'b0;
        bus.list_format = 2'b10;
        bus.wcount      = 2'b10;
        bus.aad         = 7'h55;
        bus.bad         = 7'h66;
        bus.cad         = 7'h77;
        bus.dl_temp     = ~DT;
    endtask

    initial begin
        bus.dlp_rstn_mc = 1'b0;
        bus.cmd_valid   = 1'b0;
        bus.list_format = 2'b00;
        bus.wcount      = 2'b00;
        bus.wvs         = 1'b0;
        bus.aad         = 7'd0;
        bus.bad         = 7'd0;
        bus.cad         = 7'd0;
        bus.dl_temp     = '0;
        bus.vsync_pulse = 1'b0;
        bus.reg_wr_ack  = 1'b0;
        bus.hand_done   = 1'b0;

        #12;
        chk("rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("rst_idle", {31'd0, bus.dlp_idle}, 32'd1);
        chk("rst_req", {31'd0, bus.reg_wr_req}, 32'd0);
        chk("rst_addr", {25'd0, bus.reg_wr_addr}, 32'd0);
        chk("rst_data", bus.reg_wr_data, 32'd0);
        chk("rst_hs", {31'd0, bus.hand_start}, 32'd0);
        chk("rst_fmt", {30'd0, bus.hand_fmt}, 32'd0);
        chk("rst_done", {31'd0, bus.entry_done}, 32'd0);
        hb_rstn = 1'b1;
        tick();

        // REG3, wcount 00, ack held high: three back-to-back writes.
        present(FMT_REG3, 2'b00, 1'b0, 7'h10, 7'h20, 7'h30);
        bus.reg_wr_ack = 1'b1;
        chk("s1_ready", {31'd0, bus.cmd_ready}, 32'd1);
        tick();
        scramble();
        chk_write("s1_w0", 7'h10, 32'hBBBBBBBB);
        chk("s1_busy", {31'd0, bus.dlp_idle}, 32'd0);
        tick();
        chk_write("s1_w1", 7'h20, 32'hCCCCCCCC);
        tick();
        chk_write("s1_w2", 7'h30, 32'hDDDDDDDD);
        tick();
        chk("s1_edone", {31'd0, bus.entry_done}, 32'd1);
        chk("s1_noreq", {31'd0, bus.reg_wr_req}, 32'd0);
        chk("s1_nordy", {31'd0, bus.cmd_ready}, 32'd0);
        bus.reg_wr_ack = 1'b0;
        tick();
        chk("s1_idle", {31'd0, bus.dlp_idle}, 32'd1);
        chk("s1_edone0", {31'd0, bus.entry_done}, 32'd0);

        // REG3, wcount 01, ack delayed: request held five cycles.
        present(FMT_REG3, 2'b01, 1'b0, 7'h11, 7'h22, 7'h33);
        tick();
        scramble();
        for (int i = 0; i < 4; i++) begin
            chk_write("s2_hold", 7'h11, 32'hBBBBBBBB);
            tick();
        end
        chk_write("s2_ack", 7'h11, 32'hBBBBBBBB);
        bus.reg_wr_ack = 1'b1;
        tick();
        bus.reg_wr_ack = 1'b0;
        chk("s2_edone", {31'd0, bus.entry_done}, 32'd1);
        chk("s2_noreq", {31'd0, bus.reg_wr_req}, 32'd0);
        tick();

        // REG4 at 7F: address wraps to 00, 01.
        present(FMT_REG4, 2'b01, 1'b0, 7'h7F, 7'h01, 7'h02);
        bus.reg_wr_ack = 1'b1;
        tick();
        scramble();
        chk_write("s3_w0", 7'h7F, 32'hBBBBBBBB);
        tick();
        chk_write("s3_w1", 7'h00, 32'hCCCCCCCC);
        tick();
        chk_write("s3_w2", 7'h01, 32'hDDDDDDDD);
        tick();
        chk("s3_edone", {31'd0, bus.entry_done}, 32'd1);
        bus.reg_wr_ack = 1'b0;
        tick();

        // TEXT with wvs: vsync in the acceptance cycle must not release it.
        present(FMT_TEXT, 2'b00, 1'b1, 7'h01, 7'h02, 7'h03);
        bus.vsync_pulse = 1'b1;
        tick();
        scramble();
        bus.vsync_pulse = 1'b0;
`ifdef DLP_WVS_WAIT_EN
        for (int i = 1; i < 6; i++) begin
            chk("s4_wait_hs", {31'd0, bus.hand_start}, 32'd0);
            chk("s4_wait_busy", {31'd0, bus.dlp_idle}, 32'd0);
            tick();
        end
        bus.vsync_pulse = 1'b1;
        tick();
        bus.vsync_pulse = 1'b0;
`endif
        chk("s4_hs", {31'd0, bus.hand_start}, 32'd1);
        chk("s4_fmt", {30'd0, bus.hand_fmt}, 32'd3);
        tick();
        chk("s4_hs_pulse", {31'd0, bus.hand_start}, 32'd0);
        chk("s4_fmt_hold", {30'd0, bus.hand_fmt}, 32'd3);
        bus.hand_done = 1'b1;
        tick();
        bus.hand_done = 1'b0;
        chk("s4_edone", {31'd0, bus.entry_done}, 32'd1);
        tick();
        chk("s4_idle", {31'd0, bus.dlp_idle}, 32'd1);

        // Abort mid-WRITE coincident with ack, then a fresh entry.
        present(FMT_REG3, 2'b00, 1'b0, 7'h40, 7'h41, 7'h42);
        bus.reg_wr_ack = 1'b1;
        tick();
        scramble();
        chk_write("s5_w0", 7'h40, 32'hBBBBBBBB);
        tick();
        chk_write("s5_w1", 7'h41, 32'hCCCCCCCC);
        bus.dlp_rstn_mc = 1'b1;
        tick();
        bus.dlp_rstn_mc = 1'b0;
        bus.reg_wr_ack = 1'b0;
        chk("s5_abort_req", {31'd0, bus.reg_wr_req}, 32'd0);
        chk("s5_abort_idle", {31'd0, bus.dlp_idle}, 32'd1);
        chk("s5_abort_edone", {31'd0, bus.entry_done}, 32'd0);
        tick();
        chk("s5_abort_edone2", {31'd0, bus.entry_done}, 32'd0);
        present(FMT_REG3, 2'b10, 1'b0, 7'h50, 7'h51, 7'h52);
        bus.reg_wr_ack = 1'b1;
        tick();
        scramble();
        chk_write("s5_n0", 7'h50, 32'hBBBBBBBB);
        tick();
        chk_write("s5_n1", 7'h51, 32'hCCCCCCCC);
        tick();
        chk("s5_n_edone", {31'd0, bus.entry_done}, 32'd1);
        bus.reg_wr_ack = 1'b0;
        tick();

        // Asynchronous reset while in HAND; a late hand_done is ignored.
        present(FMT_DMA, 2'b00, 1'b0, 7'h01, 7'h02, 7'h03);
        tick();
        scramble();
        chk("s6_hs", {31'd0, bus.hand_start}, 32'd1);
        chk("s6_fmt", {30'd0, bus.hand_fmt}, 32'd2);
        #2;
        hb_rstn = 1'b0;
        #1;
        chk("s6_rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("s6_rst_idle", {31'd0, bus.dlp_idle}, 32'd1);
        chk("s6_rst_hs", {31'd0, bus.hand_start}, 32'd0);
        chk("s6_rst_fmt", {30'd0, bus.hand_fmt}, 32'd0);
        chk("s6_rst_req", {31'd0, bus.reg_wr_req}, 32'd0);
        tick();
        hb_rstn = 1'b1;
        bus.hand_done = 1'b1;
        tick();
        bus.hand_done = 1'b0;
        chk("s6_no_edone", {31'd0, bus.entry_done}, 32'd0);
        chk("s6_still_idle", {31'd0, bus.dlp_idle}, 32'd1);
        tick();
        chk("s6_no_edone2", {31'd0, bus.entry_done}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
